iic_txn_ctrl: RTL and testbench

//  Register-level transaction sequencer for the byte-level I2C master core.

---
 rtl/iic_txn_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_iic_txn_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_txn_ctrl.sv
// Register-level I2C transaction sequencer: expands one register read/write
// command into START/WRITE/READ/STOP micro-ops paced on the core busy handshake.
module iic_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       core_start,
  output logic       core_stop,
  output logic       core_rw,
  output logic [7:0] core_din,
  input  logic       core_busy,
  input  logic [7:0] core_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_START,
    OP_WRITE,
    OP_READ,
    OP_STOP
  } op_kind_t;

  typedef struct packed {
    op_kind_t   kind;
    logic [7:0] data;
  } op_t;

  // The watchdog fires on the TIMEOUT_CYCLES-th counted wait cycle, so the
  // counter only ever has to hold TIMEOUT_CYCLES-1.
  localparam int TMO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_M1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  function automatic op_t op_decode(input logic [2:0] step, input logic rw,
                                    input logic [6:0] dev, input logic [7:0] ra,
                                    input logic [7:0] wd);
    op_t op;
    op.kind = OP_STOP;
    op.data = 8'h00;
    if (!rw) begin
      case (step)
        3'd0:    begin op.kind = OP_START; op.data = {dev, 1'b0}; end
        3'd1:    begin op.kind = OP_WRITE; op.data = ra;          end
        3'd2:    begin op.kind = OP_WRITE; op.data = wd;          end
        default: begin op.kind = OP_STOP;  op.data = 8'h00;       end
      endcase
    end else begin
      case (step)
        3'd0:    begin op.kind = OP_START; op.data = {dev, 1'b0}; end
        3'd1:    begin op.kind = OP_WRITE; op.data = ra;          end
        3'd2:    begin op.kind = OP_STOP;  op.data = 8'h00;       end
        3'd3:    begin op.kind = OP_START; op.data = {dev, 1'b1}; end
        3'd4:    begin op.kind = OP_READ;  op.data = 8'h00;       end
        default: begin op.kind = OP_STOP;  op.data = 8'h00;       end
      endcase
    end
    return op;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    regaddr_q, regaddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          core_rw_q, core_rw_d;
  logic [7:0]    core_din_q, core_din_d;

  op_t        op_cur;
  op_t        op_nxt;
  logic [2:0] last_step;
  logic       tmo_hit;
  logic       timeout;

  assign op_cur    = op_decode(step_q, rw_q, dev_q, regaddr_q, wdata_q);
  assign last_step = rw_q ? 3'd5 : 3'd3;
  assign tmo_hit   = TMO_EN && (wdog_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    wdog_d     = wdog_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    regaddr_d  = regaddr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    core_rw_d  = core_rw_q;
    core_din_d = core_din_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    core_start = 1'b0;
    core_stop  = 1'b0;
    timeout    = 1'b0;
    op_nxt     = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = reset_n;
        if (cmd_valid && reset_n) begin
          rw_d      = cmd_rw;
          dev_d     = cmd_dev;
          regaddr_d = cmd_reg;
          wdata_d   = cmd_wdata;
          step_d    = 3'd0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_cur.kind == OP_STOP) core_stop = 1'b1;
        else                        core_start = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (core_busy) begin
          wdog_d  = '0;
          state_d = S_WAIT_LO;
        end else if (tmo_hit) begin
          timeout = 1'b1;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!core_busy) begin
          if (op_cur.kind == OP_READ) rdata_d = core_dout;
          if (step_q == last_step) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (tmo_hit) begin
          timeout = 1'b1;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: report the error and release the bus with a STOP in the same cycle.
    if (timeout) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
      core_stop = 1'b1;
      state_d   = S_IDLE;
    end

    // Load the byte/direction as ISSUE is entered so they are already valid
    // during the pulse and stay put until the core finishes the op.
    op_nxt = op_decode(step_d, rw_d, dev_d, regaddr_d, wdata_d);
    if (state_d == S_ISSUE && state_q != S_ISSUE) begin
      core_rw_d  = (op_nxt.kind == OP_READ);
      core_din_d = (op_nxt.kind == OP_START || op_nxt.kind == OP_WRITE) ? op_nxt.data : 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      wdog_q     <= '0;
      rw_q       <= 1'b0;
      dev_q      <= 7'h00;
      regaddr_q  <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      core_rw_q  <= 1'b0;
      core_din_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      wdog_q     <= wdog_d;
      rw_q       <= rw_d;
      dev_q      <= dev_d;
      regaddr_q  <= regaddr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      core_rw_q  <= core_rw_d;
      core_din_q <= core_din_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign core_rw   = core_rw_q;
  assign core_din  = core_din_q;

endmodule

// File: tb/tb_iic_txn_ctrl.sv
// Directed bench for iic_txn_ctrl with a simple byte-core model that logs
// every micro-op pulse and answers with a fixed busy time.
module tb_iic_txn_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       core_start;
  logic       core_stop;
  logic       core_rw;
  logic [7:0] core_din;
  logic       core_busy;
  logic [7:0] core_dout;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse log entries: {is_stop, rw, din}
  logic [9:0] log_q[$];
  int         log_base = 0;
  int         rsp_cnt  = 0;
  logic       model_dead = 1'b0;

  always #5 clock = ~clock;

  iic_txn_ctrl #(.TIMEOUT_CYCLES(16), .TW(12)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_dev    (cmd_dev),
    .cmd_reg    (cmd_reg),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .core_start (core_start),
    .core_stop  (core_stop),
    .core_rw    (core_rw),
    .core_din   (core_din),
    .core_busy  (core_busy),
    .core_dout  (core_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] getlog(input int idx);
    if (log_base + idx < log_q.size()) return log_q[log_base + idx];
    return 10'h3FF;
  endfunction

  function automatic int loglen();
    return log_q.size() - log_base;
  endfunction

  // Core model: busy rises right after a pulse and stays high for three cycles.
  task automatic core_model();
    int         busy_cnt = 0;
    logic [7:0] held_din = 8'h00;
    logic       prev_start = 1'b0;
    logic       prev_stop = 1'b0;
    logic       prev_rsp = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        core_busy  = 1'b0;
        busy_cnt   = 0;
        prev_start = 1'b0;
        prev_stop  = 1'b0;
        prev_rsp   = 1'b0;
      end else begin
        chk("start_stop_excl", 32'(core_start && core_stop), 0);
        chk("start_width", 32'(core_start && prev_start), 0);
        chk("stop_width", 32'(core_stop && prev_stop), 0);
        chk("rsp_width", 32'(rsp_valid && prev_rsp), 0);
        if (rsp_valid) rsp_cnt++;
        if (core_start) log_q.push_back({1'b0, core_rw, core_din});
        else if (core_stop) log_q.push_back(10'h200);
        if ((core_start || core_stop) && !model_dead) begin
          core_busy = 1'b1;
          busy_cnt  = 3;
          held_din  = core_din;
        end else if (busy_cnt > 0) begin
          chk("din_stable", 32'(core_din), 32'(held_din));
          busy_cnt--;
          if (busy_cnt == 0) core_busy = 1'b0;
        end
        prev_start = core_start;
        prev_stop  = core_stop;
        prev_rsp   = rsp_valid;
      end
    end
  endtask

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                      input logic [7:0] wd);
    bit rdy = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin rdy = 1; break; end
      @(posedge clock); #1;
    end
    chk("cmd_ready_wait", 32'(rdy), 1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_dev   = dev;
    cmd_reg   = ra;
    cmd_wdata = wd;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'($urandom);
    cmd_dev   = 7'($urandom);
    cmd_reg   = 8'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) begin ok = 1; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    int saved_cnt;
    core_busy = 1'b0;
    fork
      core_model();
    join_none
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_dev   = 7'h00;
    cmd_reg   = 8'h00;
    cmd_wdata = 8'h00;
    core_dout = 8'h00;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_stop", 32'(core_stop), 0);
    chk("rst_core_rw", 32'(core_rw), 0);
    chk("rst_core_din", 32'(core_din), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // 1: register write
    log_base = log_q.size();
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp(ok);
    chk("wr_rsp_seen", 32'(ok), 1);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_len", 32'(loglen()), 4);
    chk("wr_op0", 32'(getlog(0)), 32'h0A0);
    chk("wr_op1", 32'(getlog(1)), 32'h010);
    chk("wr_op2", 32'(getlog(2)), 32'h0A5);
    chk("wr_op3", 32'(getlog(3)), 32'h200);
    @(posedge clock); #1;
    chk("wr_rsp_pulse", 32'(rsp_valid), 0);
    chk("wr_ready_after", 32'(cmd_ready), 1);
    chk("wr_rsp_cnt", 32'(rsp_cnt), 1);

    // 2: register read
    core_dout = 8'h3C;
    log_base = log_q.size();
    send(1'b1, 7'h50, 8'h22, 8'h00);
    wait_rsp(ok);
    chk("rd_rsp_seen", 32'(ok), 1);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    chk("rd_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_len", 32'(loglen()), 6);
    chk("rd_op0", 32'(getlog(0)), 32'h0A0);
    chk("rd_op1", 32'(getlog(1)), 32'h022);
    chk("rd_op2", 32'(getlog(2)), 32'h200);
    chk("rd_op3", 32'(getlog(3)), 32'h0A1);
    chk("rd_op4", 32'(getlog(4)), 32'h100);
    chk("rd_op5", 32'(getlog(5)), 32'h200);
    @(posedge clock); #1;
    chk("rd_rsp_cnt", 32'(rsp_cnt), 2);

    // 3: core never raises busy -> watchdog
    model_dead = 1'b1;
    core_dout = 8'h77;
    log_base = log_q.size();
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_dev   = 7'h50;
    cmd_reg   = 8'h10;
    cmd_wdata = 8'hA5;
    chk("tmo_ready", 32'(cmd_ready), 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("tmo_issue_start", 32'(core_start), 1);
    for (int k = 0; k < 15; k++) begin
      @(posedge clock); #1;
      chk("tmo_early_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clock); #1;
    chk("tmo_rsp_valid", 32'(rsp_valid), 1);
    chk("tmo_rsp_err", 32'(rsp_err), 1);
    chk("tmo_core_stop", 32'(core_stop), 1);
    chk("tmo_core_start", 32'(core_start), 0);
    chk("tmo_rdata_kept", 32'(rsp_rdata), 32'h3C);
    @(posedge clock); #1;
    chk("tmo_ready_next", 32'(cmd_ready), 1);
    chk("tmo_stop_once", 32'(core_stop), 0);
    chk("tmo_len", 32'(loglen()), 2);
    chk("tmo_op0", 32'(getlog(0)), 32'h0A0);
    chk("tmo_op1", 32'(getlog(1)), 32'h200);
    chk("tmo_rsp_cnt", 32'(rsp_cnt), 3);
    model_dead = 1'b0;

    // 4: cmd_valid held high across a write then a read
    core_dout = 8'h96;
    log_base = log_q.size();
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_dev   = 7'h33;
    cmd_reg   = 8'h44;
    cmd_wdata = 8'h5A;
    @(posedge clock); #1;
    chk("b2b_issue1", 32'(core_start), 1);
    chk("b2b_din1", 32'(core_din), 32'h66);
    cmd_rw    = 1'b1;
    cmd_dev   = 7'h21;
    cmd_reg   = 8'h77;
    cmd_wdata = 8'hEE;
    wait_rsp(ok);
    chk("b2b_rsp1_seen", 32'(ok), 1);
    chk("b2b_rsp1_err", 32'(rsp_err), 0);
    chk("b2b_busy_ready", 32'(cmd_ready), 0);
    @(posedge clock); #1;
    chk("b2b_ready", 32'(cmd_ready), 1);
    chk("b2b_rsp1_pulse", 32'(rsp_valid), 0);
    @(posedge clock); #1;
    chk("b2b_issue2", 32'(core_start), 1);
    chk("b2b_din2", 32'(core_din), 32'h42);
    chk("b2b_rw2", 32'(core_rw), 0);
    cmd_valid = 1'b0;
    chk("b2b_w_op0", 32'(getlog(0)), 32'h066);
    chk("b2b_w_op1", 32'(getlog(1)), 32'h044);
    chk("b2b_w_op2", 32'(getlog(2)), 32'h05A);
    chk("b2b_w_op3", 32'(getlog(3)), 32'h200);
    wait_rsp(ok);
    chk("b2b_rsp2_seen", 32'(ok), 1);
    chk("b2b_rdata", 32'(rsp_rdata), 32'h96);
    chk("b2b_len", 32'(loglen()), 10);
    chk("b2b_r_op1", 32'(getlog(5)), 32'h077);
    chk("b2b_r_op3", 32'(getlog(7)), 32'h043);
    chk("b2b_r_op4", 32'(getlog(8)), 32'h100);
    chk("b2b_r_op5", 32'(getlog(9)), 32'h200);
    @(posedge clock); #1;

    // 5: reset during the READ byte
    core_dout = 8'h5D;
    log_base = log_q.size();
    send(1'b1, 7'h11, 8'h0F, 8'h00);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (loglen() >= 5) begin ok = 1; break; end
      @(posedge clock); #1;
    end
    chk("mid_reached_read", 32'(ok), 1);
    chk("mid_core_rw", 32'(core_rw), 1);
    saved_cnt = rsp_cnt;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_ready", 32'(cmd_ready), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 0);
    chk("mid_rst_start", 32'(core_start), 0);
    chk("mid_rst_stop", 32'(core_stop), 0);
    chk("mid_rst_rw", 32'(core_rw), 0);
    chk("mid_rst_din", 32'(core_din), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("mid_ready_after", 32'(cmd_ready), 1);
    chk("mid_no_rsp", 32'(rsp_cnt), 32'(saved_cnt));
    log_base = log_q.size();
    send(1'b0, 7'h2A, 8'h01, 8'hC3);
    wait_rsp(ok);
    chk("post_rsp_seen", 32'(ok), 1);
    chk("post_rsp_err", 32'(rsp_err), 0);
    chk("post_op0", 32'(getlog(0)), 32'h054);
    chk("post_op1", 32'(getlog(1)), 32'h001);
    chk("post_op2", 32'(getlog(2)), 32'h0C3);
    chk("post_op3", 32'(getlog(3)), 32'h200);
    repeat (3) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
